// File: rtl/demux_route_pkg.sv
// demux_route_pkg: shared select codes and default widths for the four-way router
package demux_route_pkg;
  localparam logic [1:0] OP_A = 2'b00;
  localparam logic [1:0] OP_B = 2'b01;
  localparam logic [1:0] OP_C = 2'b10;
  localparam logic [1:0] OP_D = 2'b11;
  localparam int NUM_CH = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output holding register with valid/ready and wrapping delivery counter
module demux_slot
  import demux_route_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_ready
);
  logic fire;
  assign fire = out_valid && out_ready;
  assign slot_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= load ? 1'b1 : (fire ? 1'b0 : out_valid);
      if (load) out_data <= load_data;
      if (fire) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/demux_route.sv
// demux_route: routes each accepted word to one of four registered output channels by op
module demux_route
  import demux_route_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data,
  output logic [WIDTH-1:0] c_data,
  output logic [WIDTH-1:0] d_data,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] c_cnt,
  output logic [CNT_W-1:0] d_cnt
);
  logic [NUM_CH-1:0] load, vld, rdy, srdy;
  logic [WIDTH-1:0]  dat [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];
  assign rdy = {d_ready, c_ready, b_ready, a_ready};
  assign in_ready = srdy[in_op];
  assign load = (in_valid && in_ready) ? (NUM_CH'(1) << in_op) : '0;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (in_data),
      .out_valid (vld[i]),
      .out_ready (rdy[i]),
      .out_data  (dat[i]),
      .cnt       (cnt[i]),
      .slot_ready(srdy[i])
    );
  end
  assign {d_valid, c_valid, b_valid, a_valid} = vld;
  assign a_data = dat[OP_A];
  assign b_data = dat[OP_B];
  assign c_data = dat[OP_C];
  assign d_data = dat[OP_D];
  assign a_cnt = cnt[OP_A];
  assign b_cnt = cnt[OP_B];
  assign c_cnt = cnt[OP_C];
  assign d_cnt = cnt[OP_D];
endmodule

// File: tb/tb_demux_route.sv
// tb_demux_route: directed self-checking bench for the four-way demux router
module tb_demux_route;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_op;
  logic       in_valid, in_ready;
  logic [7:0] a_data, b_data, c_data, d_data;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic [7:0] a_cnt, b_cnt, c_cnt, d_cnt;
  logic [7:0] dat [4];
  logic       vld [4];
  int passed = 0;
  int total = 0;
  demux_route dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_op(in_op), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_data(b_data), .c_data(c_data), .d_data(d_data),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .c_cnt(c_cnt), .d_cnt(d_cnt)
  );
  always #5 clk = ~clk;
  assign dat[0] = a_data;
  assign dat[1] = b_data;
  assign dat[2] = c_data;
  assign dat[3] = d_data;
  assign vld[0] = a_valid;
  assign vld[1] = b_valid;
  assign vld[2] = c_valid;
  assign vld[3] = d_valid;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    in_data = '0;
    in_op = '0;
    in_valid = 1'b0;
    {a_ready, b_ready, c_ready, d_ready} = '0;
    #12;
    chk("rst_valids", {a_valid, b_valid, c_valid, d_valid}, 0);
    chk("rst_data", {a_data, b_data, c_data, d_data}, 0);
    chk("rst_cnts", {a_cnt, b_cnt, c_cnt, d_cnt}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick;
    in_op = 2'b10; in_data = 8'h5A; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("c_valid_load", c_valid, 1);
    chk("c_data_load", c_data, 8'h5A);
    chk("others_idle", {a_valid, b_valid, d_valid}, 0);
    chk("cnts_zero", {a_cnt, b_cnt, c_cnt, d_cnt}, 0);
    in_op = 2'b10; in_data = 8'h77; in_valid = 1'b1;
    #1;
    chk("stall_c_full", in_ready, 0);
    tick;
    chk("c_held", c_data, 8'h5A);
    chk("a_not_loaded", a_valid, 0);
    in_op = 2'b00;
    #1;
    chk("ready_a_while_c_full", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("a_valid_switch", a_valid, 1);
    chk("a_data_switch", a_data, 8'h77);
    chk("c_still_5a", c_data, 8'h5A);
    {a_ready, b_ready, c_ready, d_ready} = 4'hF;
    tick;
    chk("multi_drain_valids", {a_valid, c_valid}, 0);
    chk("multi_drain_cnts", {a_cnt, c_cnt}, 16'h0101);
    chk("a_data_held_after_drain", a_data, 8'h77);
    pulse_reset;
    chk("reset_pulse_cnts", {a_cnt, b_cnt, c_cnt, d_cnt}, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_op = 2'(i % 4);
      in_data = 8'(i);
      #1;
      chk("stream_in_ready", in_ready, 1);
      tick;
      chk("stream_order_data", dat[i % 4], 8'(i));
      chk("stream_valid", vld[i % 4], 1);
    end
    in_valid = 1'b0;
    tick;
    chk("stream_cnts", {a_cnt, b_cnt, c_cnt, d_cnt}, 32'h10101010);
    chk("stream_empty", {a_valid, b_valid, c_valid, d_valid}, 0);
    {a_ready, b_ready, c_ready, d_ready} = '0;
    in_op = 2'b01; in_data = 8'h11; in_valid = 1'b1;
    tick;
    chk("b_full", b_valid, 1);
    b_ready = 1'b1; in_data = 8'hC3;
    #1;
    chk("b_pass_through_ready", in_ready, 1);
    tick;
    in_valid = 1'b0; b_ready = 1'b0;
    chk("b_simul_valid", b_valid, 1);
    chk("b_simul_data", b_data, 8'hC3);
    chk("b_simul_cnt", b_cnt, 8'd17);
    b_ready = 1'b1;
    tick;
    b_ready = 1'b0;
    chk("b_final_drain_valid", b_valid, 0);
    chk("b_final_drain_cnt", b_cnt, 8'd18);
    pulse_reset;
    d_ready = 1'b1; in_op = 2'b11; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      tick;
    end
    in_valid = 1'b0;
    chk("d_cnt_255", d_cnt, 8'hFF);
    chk("d_last_word", d_data, 8'hFF);
    tick;
    chk("d_cnt_wrap", d_cnt, 8'h00);
    chk("d_empty", d_valid, 0);
    {a_ready, b_ready, c_ready, d_ready} = '0;
    in_op = 2'b00; in_data = 8'h11; in_valid = 1'b1;
    tick;
    a_ready = 1'b1; in_data = 8'hA1;
    tick;
    a_ready = 1'b0; in_op = 2'b11; in_data = 8'hD4;
    tick;
    in_valid = 1'b0;
    chk("pre_reset_full", {a_valid, d_valid}, 2'b11);
    chk("pre_reset_a", {a_data, a_cnt}, 16'hA101);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_valids", {a_valid, b_valid, c_valid, d_valid}, 0);
    chk("async_cnts", {a_cnt, b_cnt, c_cnt, d_cnt}, 0);
    chk("async_data", {a_data, d_data}, 0);
    chk("async_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
